// File: rtl/dispatch_ctrl_param.sv
// dispatch_ctrl_param: in-order Tomasulo dispatch with tag free list, RST, CDB forwarding and branch stall; define DISPATCH_CDB_BYPASS_EN to forward CDB data into operands
module dispatch_ctrl_param #(
  parameter int NUM_Q = 4,
  parameter int TAG_W = 6,
  parameter int XLEN = 32,
  parameter int ARCH_W = 5,
  localparam int QW = NUM_Q > 1 ? $clog2(NUM_Q) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_instr_valid,
  input  logic [QW-1:0]     i_q_sel,
  input  logic              i_is_branch,
  input  logic              i_rd_wr,
  input  logic [ARCH_W-1:0] i_rd_addr,
  input  logic [ARCH_W-1:0] i_rs1_addr,
  input  logic [ARCH_W-1:0] i_rs2_addr,
  input  logic [XLEN-1:0]   i_rs1_rf_data,
  input  logic [XLEN-1:0]   i_rs2_rf_data,
  input  logic [NUM_Q-1:0]  i_q_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [XLEN-1:0]   cdb_data,
  input  logic              cdb_branch,
  input  logic              cdb_branch_taken,
  output logic [NUM_Q-1:0]  o_dispatch_en,
  output logic              o_fetch_rd_en,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [TAG_W:0]    o_rs1_tag,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [TAG_W:0]    o_rs2_tag,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic              o_rf_wen,
  output logic [ARCH_W-1:0] o_rf_waddr,
  output logic              o_redirect,
  output logic              o_br_stall,
  output logic              o_tags_empty
);
  localparam int DEPTH = 1 << TAG_W;
  localparam int NREG = 1 << ARCH_W;
  localparam logic [TAG_W:0] FULL = (TAG_W + 1)'(DEPTH);
`ifdef DISPATCH_CDB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  typedef enum logic {IDLE, BR_WAIT} state_t;
  state_t state;
  logic [TAG_W-1:0] fl_mem [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0] count;
  logic [NREG-1:0] pend, hit;
  logic [TAG_W-1:0] rtag [NREG];
  logic need_tag, fire, push, pop, byp_stall, p1, p2, h1, h2;
  assign need_tag = i_rd_wr & (i_rd_addr != '0);
  assign o_tags_empty = count == '0;
  assign o_rd_tag = fl_mem[head];
  assign o_redirect = cdb_branch & cdb_branch_taken;
  assign p1 = (i_rs1_addr != '0) & pend[i_rs1_addr];
  assign p2 = (i_rs2_addr != '0) & pend[i_rs2_addr];
  assign h1 = p1 & cdb_valid & (rtag[i_rs1_addr] == cdb_tag);
  assign h2 = p2 & cdb_valid & (rtag[i_rs2_addr] == cdb_tag);
  assign o_rs1_tag = (p1 & ~(BYP & h1)) ? {1'b1, rtag[i_rs1_addr]} : '0;
  assign o_rs2_tag = (p2 & ~(BYP & h2)) ? {1'b1, rtag[i_rs2_addr]} : '0;
  assign o_rs1_data = (i_rs1_addr == '0) ? '0 : (BYP & h1) ? cdb_data : i_rs1_rf_data;
  assign o_rs2_data = (i_rs2_addr == '0) ? '0 : (BYP & h2) ? cdb_data : i_rs2_rf_data;
  // without forwarding, wait one cycle so the retiring value is read from the RF
  assign byp_stall = ~BYP & (h1 | h2);
  assign fire = i_rst_n & i_instr_valid & ~i_q_full[i_q_sel] & ~(need_tag & o_tags_empty)
              & (state == IDLE) & ~byp_stall;
  assign o_dispatch_en = NUM_Q'(fire) << i_q_sel;
  assign o_fetch_rd_en = fire;
  assign pop = fire & need_tag;
  assign push = cdb_valid & ((count != FULL) | pop);
  assign o_rf_wen = |hit;
  always_comb begin
    o_rf_waddr = '0;
    for (int r = 0; r < NREG; r++) begin
      hit[r] = cdb_valid & pend[r] & (rtag[r] == cdb_tag);
      if (hit[r]) o_rf_waddr = ARCH_W'(r);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) fl_mem[i] <= TAG_W'(i);
      head <= '0;
      tail <= '0;
      count <= FULL;
    end else begin
      if (push) begin
        fl_mem[tail] <= cdb_tag;
        tail <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + (TAG_W + 1)'(push) - (TAG_W + 1)'(pop);
    end
  end
  // a new dispatch to the same register overrides the CDB clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend <= '0;
      for (int r = 0; r < NREG; r++) rtag[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) if (hit[r]) pend[r] <= 1'b0;
      if (pop) begin
        pend[i_rd_addr] <= 1'b1;
        rtag[i_rd_addr] <= o_rd_tag;
      end
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_br_stall <= 1'b0;
    end else if (state == IDLE && fire && i_is_branch) begin
      state <= BR_WAIT;
      o_br_stall <= 1'b1;
    end else if (state == BR_WAIT && cdb_branch) begin
      state <= IDLE;
      o_br_stall <= 1'b0;
    end
  end
  assert property (@(posedge i_clk) disable iff (!i_rst_n) !(cdb_valid && count == FULL && !pop));
endmodule

// File: tb/tb_dispatch_ctrl_param.sv
// tb_dispatch_ctrl_param: scoreboard bench for dispatch_ctrl_param
module tb_dispatch_ctrl_param;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic iv, is_br, rd_wr, cdb_valid, cdb_branch, cdb_taken;
  logic [1:0] q_sel;
  logic [4:0] rd, rs1, rs2;
  logic [31:0] rf1, rf2, cdb_data;
  logic [3:0] q_full;
  logic [5:0] cdb_tag;
  logic [3:0] dispatch_en;
  logic fetch_rd_en, rf_wen, redirect, br_stall, tags_empty;
  logic [5:0] rd_tag;
  logic [6:0] rs1_tag, rs2_tag;
  logic [31:0] rs1_data, rs2_data;
  logic [4:0] rf_waddr;
  dispatch_ctrl_param dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr_valid(iv), .i_q_sel(q_sel), .i_is_branch(is_br),
    .i_rd_wr(rd_wr), .i_rd_addr(rd), .i_rs1_addr(rs1), .i_rs2_addr(rs2),
    .i_rs1_rf_data(rf1), .i_rs2_rf_data(rf2), .i_q_full(q_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_branch(cdb_branch), .cdb_branch_taken(cdb_taken),
    .o_dispatch_en(dispatch_en), .o_fetch_rd_en(fetch_rd_en), .o_rd_tag(rd_tag),
    .o_rs1_tag(rs1_tag), .o_rs1_data(rs1_data), .o_rs2_tag(rs2_tag), .o_rs2_data(rs2_data),
    .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_redirect(redirect),
    .o_br_stall(br_stall), .o_tags_empty(tags_empty)
  );
  typedef struct {
    logic [3:0] en;
    logic [5:0] tag;
    logic chk_tag;
    logic [6:0] t1;
    logic [31:0] d1;
    logic chk_d1;
    logic [6:0] t2;
  } exp_t;
  exp_t sbq[$];
  int pass_cnt = 0, tot_cnt = 0;
  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
  endtask
  task automatic exp_fire(input logic [3:0] en, input logic [5:0] tag, input logic ct,
                          input logic [6:0] t1, input logic [31:0] d1, input logic cd,
                          input logic [6:0] t2);
    exp_t e;
    e.en = en; e.tag = tag; e.chk_tag = ct; e.t1 = t1; e.d1 = d1; e.chk_d1 = cd; e.t2 = t2;
    sbq.push_back(e);
  endtask
  always @(negedge clk) begin
    if (fetch_rd_en) begin
      exp_t e;
      if (sbq.size() == 0) cmp("unexpected_fire", 64'(fetch_rd_en), 64'd0);
      else begin
        e = sbq.pop_front();
        cmp("dispatch_en", 64'(dispatch_en), 64'(e.en));
        if (e.chk_tag) cmp("rd_tag", 64'(rd_tag), 64'(e.tag));
        cmp("rs1_tag", 64'(rs1_tag), 64'(e.t1));
        if (e.chk_d1) cmp("rs1_data", 64'(rs1_data), 64'(e.d1));
        cmp("rs2_tag", 64'(rs2_tag), 64'(e.t2));
      end
    end
  end
  task automatic drv(input logic [1:0] q, input logic br, input logic w, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] r1);
    iv = 1'b1; q_sel = q; is_br = br; rd_wr = w; rd = d; rs1 = s1; rs2 = s2; rf1 = r1;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  initial begin
    iv = 1'b1; is_br = 1'b0; rd_wr = 1'b1; rd = 5'd1; rs1 = '0; rs2 = '0; q_sel = '0;
    rf1 = '0; rf2 = 32'h2222; q_full = '0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    cdb_branch = 1'b0; cdb_taken = 1'b0;
    @(negedge clk);
    cmp("rst_dispatch_en", 64'(dispatch_en), 64'd0);
    cmp("rst_fetch", 64'(fetch_rd_en), 64'd0);
    cmp("rst_br_stall", 64'(br_stall), 64'd0);
    cmp("rst_tags_empty", 64'(tags_empty), 64'd0);
    cmp("rst_rd_tag", 64'(rd_tag), 64'd0);
    cmp("rst_rf_wen", 64'(rf_wen), 64'd0);
    iv = 1'b0;
    #2 rst_n = 1'b1;
    cyc();
    drv(0, 0, 1, 1, 0, 0, 32'h1111); exp_fire(4'b0001, 0, 1, 0, 0, 1, 0); cyc();
    drv(0, 0, 1, 2, 1, 0, 32'h1111); exp_fire(4'b0001, 1, 1, 7'h40, 0, 0, 0); cyc();
    q_full = 4'b0100;
    drv(2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    cmp("qfull_fetch", 64'(fetch_rd_en), 64'd0);
    cmp("qfull_en", 64'(dispatch_en), 64'd0);
    cyc();
    drv(0, 0, 0, 0, 0, 0, 0); exp_fire(4'b0001, 2, 1, 0, 0, 1, 0); cyc();
    drv(3, 0, 0, 0, 0, 0, 0); exp_fire(4'b1000, 2, 1, 0, 0, 1, 0); cyc();
    q_full = '0;
    drv(1, 0, 1, 10, 0, 0, 0); exp_fire(4'b0010, 2, 1, 0, 0, 1, 0); cyc();
    drv(1, 0, 1, 11, 0, 0, 0); exp_fire(4'b0010, 3, 1, 0, 0, 1, 0); cyc();
    drv(1, 0, 1, 12, 0, 0, 0); exp_fire(4'b0010, 4, 1, 0, 0, 1, 0); cyc();
    drv(1, 0, 1, 3, 0, 0, 0); exp_fire(4'b0010, 5, 1, 0, 0, 1, 0); cyc();
    drv(0, 0, 0, 0, 3, 12, 32'h1234);
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'hABCD;
`ifdef DISPATCH_CDB_BYPASS_EN
    exp_fire(4'b0001, 6, 1, 0, 32'hABCD, 1, 7'h44);
    @(negedge clk);
    cmp("byp_rf_wen", 64'(rf_wen), 64'd1);
    cmp("byp_rf_waddr", 64'(rf_waddr), 64'd3);
    cyc();
`else
    @(negedge clk);
    cmp("byp_rf_wen", 64'(rf_wen), 64'd1);
    cmp("byp_rf_waddr", 64'(rf_waddr), 64'd3);
    cmp("byp_stall_fetch", 64'(fetch_rd_en), 64'd0);
    cyc();
    cdb_valid = 1'b0; rf1 = 32'hABCD;
    exp_fire(4'b0001, 6, 1, 0, 32'hABCD, 1, 7'h44);
    cyc();
`endif
    cdb_valid = 1'b0;
    drv(1, 1, 0, 0, 0, 0, 0); exp_fire(4'b0010, 6, 1, 0, 0, 1, 0); cyc();
    drv(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("br_stall_hold", 64'(br_stall), 64'd1);
      cmp("br_stall_fetch", 64'(fetch_rd_en), 64'd0);
      cyc();
    end
    iv = 1'b0; cdb_branch = 1'b1; cdb_taken = 1'b1;
    @(negedge clk);
    cmp("redirect", 64'(redirect), 64'd1);
    cyc();
    cdb_branch = 1'b0; cdb_taken = 1'b0;
    drv(2, 0, 0, 0, 0, 0, 0); exp_fire(4'b0100, 6, 1, 0, 0, 1, 0);
    @(negedge clk);
    cmp("br_release", 64'(br_stall), 64'd0);
    cyc();
    iv = 1'b0; cdb_branch = 1'b1;
    @(negedge clk);
    cmp("redirect_not_taken", 64'(redirect), 64'd0);
    cyc();
    cdb_branch = 1'b0;
    @(negedge clk);
    cmp("idle_branch_ignored", 64'(br_stall), 64'd0);
    cyc();
    for (int i = 0; i < 59; i++) begin
      drv(0, 0, 1, 7, 0, 0, 0);
      exp_fire(4'b0001, i < 58 ? 6'(6 + i) : 6'd5, 1, 0, 0, 1, 0);
      cyc();
    end
    drv(0, 0, 1, 7, 0, 0, 0);
    @(negedge clk);
    cmp("tags_empty", 64'(tags_empty), 64'd1);
    cmp("empty_block", 64'(fetch_rd_en), 64'd0);
    cyc();
    drv(0, 0, 1, 0, 0, 0, 0); exp_fire(4'b0001, 0, 0, 0, 0, 1, 0); cyc();
    drv(0, 0, 1, 8, 0, 0, 0); cdb_valid = 1'b1; cdb_tag = 6'd9;
    @(negedge clk);
    cmp("empty_push_block", 64'(fetch_rd_en), 64'd0);
    cmp("free_tag_no_wen", 64'(rf_wen), 64'd0);
    cyc();
    cdb_valid = 1'b0; exp_fire(4'b0001, 9, 1, 0, 0, 1, 0);
    @(negedge clk);
    cmp("refill_not_empty", 64'(tags_empty), 64'd0);
    cyc();
    iv = 1'b0; cdb_valid = 1'b1; cdb_tag = 6'd20; cyc();
    cdb_tag = 6'd31; cyc();
    cdb_valid = 1'b0;
    drv(0, 0, 1, 4, 0, 0, 0); exp_fire(4'b0001, 20, 1, 0, 0, 1, 0); cyc();
    drv(0, 0, 1, 4, 0, 0, 0); exp_fire(4'b0001, 31, 1, 0, 0, 1, 0);
    cdb_valid = 1'b1; cdb_tag = 6'd20;
    @(negedge clk);
    cmp("coll_rf_wen", 64'(rf_wen), 64'd1);
    cmp("coll_rf_waddr", 64'(rf_waddr), 64'd4);
    cyc();
    cdb_valid = 1'b0;
    drv(0, 0, 0, 0, 4, 0, 0); exp_fire(4'b0001, 20, 1, 7'h5F, 0, 0, 0); cyc();
    drv(3, 1, 0, 0, 0, 0, 0); exp_fire(4'b1000, 20, 1, 0, 0, 1, 0); cyc();
    iv = 1'b0;
    @(negedge clk);
    cmp("pre_reset_stall", 64'(br_stall), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    cmp("mid_rst_br_stall", 64'(br_stall), 64'd0);
    cmp("mid_rst_rd_tag", 64'(rd_tag), 64'd0);
    cmp("mid_rst_empty", 64'(tags_empty), 64'd0);
    #1 rst_n = 1'b1;
    cyc();
    drv(0, 0, 1, 5, 4, 0, 32'h5555); exp_fire(4'b0001, 0, 1, 0, 32'h5555, 1, 0); cyc();
    iv = 1'b0;
    cyc(); cyc();
    cmp("sb_drain", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
